distribuidor_cartas: RTL and testbench
======================================

Name: distribuidor_cartas

Overview:
Dealer controller that sequences the shuffled 52-card deck memory for one blackjack table. On the first round after reset it fires a one-cycle shuffle request and waits for shuffle-done. Each round it deals the opening hand (player, dealer, player, dealer). After that it arbitrates card requests from the player and dealer logic by driving the deck read address and returning registered card values. It sits between the game FSM/scoring logic and the deck memory, and is the only driver of the deck read address.

Parameters:
DECK_SIZE, 52, number of addressable cards (valid addresses 0..DECK_SIZE-1)
INIT_CARDS, 4, cards dealt automatically at round start, alternating player/dealer, player first
SHUFFLE_TIMEOUT, 1023, max cycles to wait for embaralhar_ok before flagging an error

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-high reset
start_round  input  1  one-cycle pulse: begin new round
embaralhar_start  output  1  one-cycle shuffle request to the deck
embaralhar_ok  input  1  deck shuffle finished (level, stays high once set)
ler_endereco  output  6  deck read address; deck returns q combinationally
q  input  4  card value at ler_endereco (1..11)
req_jogador  input  1  player requests one card (sampled each cycle)
req_banca  input  1  dealer requests one card (sampled each cycle)
card_valid  output  1  one-cycle strobe: card_value/card_dest valid
card_value  output  4  dealt card value
card_dest  output  1  0 = player, 1 = dealer
cnt_jogador  output  4  cards dealt to player this round (saturates at 15)
cnt_banca  output  4  cards dealt to dealer this round (saturates at 15)
pronto  output  1  high in SERVE: opening hand done, requests accepted
deck_empty  output  1  high once all DECK_SIZE cards are dealt
erro_shuffle  output  1  sticky; set on shuffle timeout

Behaviour:
- Reset (synchronous) values:
  - all outputs 0, ler_endereco = 0.
  - internal pointer = 0, shuffled flag = 0, state = IDLE.
  - Reset overrides every state, including mid-shuffle and mid-deal.
- States: IDLE, SHUF_REQ, SHUF_WAIT, INIT_DEAL, SERVE, EMPTY, ERROR.
- IDLE: waits for start_round.
  - If shuffled flag = 0, go to SHUF_REQ.
  - Otherwise clear cnt_* and go to INIT_DEAL; the pointer is NOT rewound, and the round continues from the current deck position.
- SHUF_REQ: drive embaralhar_start = 1 for exactly one cycle, then go to SHUF_WAIT.
- SHUF_WAIT: count cycles.
  - On embaralhar_ok = 1: set shuffled flag, clear cnt_*, go to INIT_DEAL.
  - If the count reaches SHUFFLE_TIMEOUT first: set erro_shuffle, go to ERROR.
- ERROR: terminal until reset; all requests ignored.
- Dealing a card (one card per cycle maximum):
  - ler_endereco always equals the internal pointer.
  - In a deal cycle N, q is captured. In cycle N+1: card_valid = 1, card_value = q from cycle N, card_dest = recipient.
  - Also in N+1: the pointer has incremented and the recipient's cnt_* has incremented (saturating at 15).
- INIT_DEAL: deals INIT_CARDS cards on consecutive cycles with dest sequence 0,1,0,1.
  - req_* inputs are ignored during INIT_DEAL.
  - After the last card, go to SERVE (pronto = 1 from the following cycle).
- SERVE: each cycle, if exactly one of req_jogador/req_banca is high, deal to that requester.
  - If both are high, the player wins; the dealer request is dropped and the requester must re-assert.
  - A request held high deals one card per cycle.
  - start_round in SERVE clears cnt_*, deasserts pronto and goes to INIT_DEAL. If a request arrives in the same cycle, start_round wins and the request is dropped.
- Deck exhaustion: when the pointer reaches DECK_SIZE after a deal, set deck_empty and go to EMPTY, whether in INIT_DEAL or SERVE.
  - A partial opening hand is permitted; the cards already dealt remain valid.
  - In EMPTY, requests and start_round are ignored, no card_valid is issued, and ler_endereco holds at DECK_SIZE.
  - EMPTY is left only by reset.
- Width rules:
  - pointer is 6 bits and never exceeds DECK_SIZE.
  - No address >= DECK_SIZE is ever used for a deal.

Test Plan:
- Reset, then start_round pulse → embaralhar_start high for exactly 1 cycle. After embaralhar_ok rises, 4 card_valid strobes on consecutive cycles: dest 0,1,0,1, addresses 0..3. End state: cnt_jogador = 2, cnt_banca = 2, pronto = 1.
- In SERVE, assert req_jogador and req_banca in the same cycle → one card to player (dest = 0), none to dealer. Re-asserting req_banca alone → dest = 1, cnt_banca = 3.
- Hold req_jogador for 48 cycles after the opening hand → 48 strobes, deck_empty = 1 after the address-51 card. Further requests produce no card_valid, and ler_endereco = 52.
- Keep embaralhar_ok = 0 for SHUFFLE_TIMEOUT cycles after the request → erro_shuffle = 1 and no card_valid. The block stays in ERROR until reset; a subsequent start_round has no effect.
- Second start_round after 6 cards are dealt → no embaralhar_start; cnt_* cleared to 0; opening hand read from addresses 6..9.
- Assert reset during INIT_DEAL (after 2 cards) → next cycle: all outputs 0, pointer 0. The next start_round issues embaralhar_start again.

Source files
------------

// File: rtl/distribuidor_cartas_if.sv
// -----------------------------------------------------------------------------
// distribuidor_cartas_if
// Groups every signal between the card dealer, the game FSM/scoring logic and
// the deck memory.
//   master : environment side (game logic + deck memory)
//   slave  : the dealer controller (distribuidor_cartas)
// Signals:
//   start_round      game -> dealer   one-cycle pulse, begin a new round
//   embaralhar_start dealer -> deck   one-cycle shuffle request
//   embaralhar_ok    deck -> dealer   shuffle finished (level)
//   ler_endereco     dealer -> deck   deck read address
//   q                deck -> dealer   card value at ler_endereco (combinational)
//   req_jogador      game -> dealer   player card request
//   req_banca        game -> dealer   dealer card request
//   card_valid       dealer -> game   one-cycle strobe for card_value/card_dest
//   card_value       dealer -> game   dealt card value
//   card_dest        dealer -> game   0 = player, 1 = dealer
//   cnt_jogador      dealer -> game   cards dealt to player this round
//   cnt_banca        dealer -> game   cards dealt to dealer this round
//   pronto           dealer -> game   opening hand done, requests accepted
//   deck_empty       dealer -> game   whole deck dealt
//   erro_shuffle     dealer -> game   sticky shuffle timeout flag
// -----------------------------------------------------------------------------
interface distribuidor_cartas_if;
    logic       start_round;
    logic       embaralhar_start;
    logic       embaralhar_ok;
    logic [5:0] ler_endereco;
    logic [3:0] q;
    logic       req_jogador;
    logic       req_banca;
    logic       card_valid;
    logic [3:0] card_value;
    logic       card_dest;
    logic [3:0] cnt_jogador;
    logic [3:0] cnt_banca;
    logic       pronto;
    logic       deck_empty;
    logic       erro_shuffle;

    modport master (
        output start_round, embaralhar_ok, q, req_jogador, req_banca,
        input  embaralhar_start, ler_endereco, card_valid, card_value,
               card_dest, cnt_jogador, cnt_banca, pronto, deck_empty,
               erro_shuffle
    );

    modport slave (
        input  start_round, embaralhar_ok, q, req_jogador, req_banca,
        output embaralhar_start, ler_endereco, card_valid, card_value,
               card_dest, cnt_jogador, cnt_banca, pronto, deck_empty,
               erro_shuffle
    );
endinterface

// File: rtl/distribuidor_cartas.sv
// -----------------------------------------------------------------------------
// distribuidor_cartas
// Dealer controller for one blackjack table. Requests a deck shuffle on the
// first round after reset, deals the opening hand (player, dealer, player,
// dealer) and then serves player/dealer card requests, player first. It is the
// only driver of the deck read address; card values come back registered one
// cycle after the read.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : distribuidor_cartas_if.slave (see interface for signal list)
// -----------------------------------------------------------------------------
module distribuidor_cartas #(
    parameter int DECK_SIZE       = 52,
    parameter int INIT_CARDS      = 4,
    parameter int SHUFFLE_TIMEOUT = 1023
) (
    input  logic                  clock,
    input  logic                  reset,
    distribuidor_cartas_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, SHUF_REQ, SHUF_WAIT, INIT_DEAL, SERVE, EMPTY, ERROR
    } state_t;

    localparam int              TW           = $clog2(SHUFFLE_TIMEOUT + 1);
    localparam logic [5:0]      LAST_ADDR    = 6'(DECK_SIZE - 1);
    localparam logic [5:0]      DECK_END     = 6'(DECK_SIZE);
    localparam logic [3:0]      INIT_LAST    = 4'(INIT_CARDS - 1);
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(SHUFFLE_TIMEOUT - 1);

    state_t          state;
    logic [5:0]      ptr;
    logic            shuffled;
    logic [TW-1:0]   wait_cnt;
    logic [3:0]      init_idx;

    logic            embaralhar_start;
    logic            card_valid;
    logic [3:0]      card_value;
    logic            card_dest;
    logic [3:0]      cnt_jogador;
    logic [3:0]      cnt_banca;
    logic            pronto;
    logic            deck_empty;
    logic            erro_shuffle;

    logic            deal_en;
    logic            deal_dest;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    // Deal decision for this cycle. start_round in SERVE takes precedence over
    // any request; the pointer guard keeps addresses >= DECK_SIZE from ever
    // being dealt.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        deal_en   = 1'b0;
        deal_dest = 1'b0;
        case (state)
            INIT_DEAL: begin
                deal_en   = 1'b1;
                deal_dest = init_idx[0];
            end
            SERVE: begin
                if (!bus.start_round) begin
                    if (bus.req_jogador) begin
                        deal_en   = 1'b1;
                        deal_dest = 1'b0;
                    end else if (bus.req_banca) begin
                        deal_en   = 1'b1;
                        deal_dest = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (ptr >= DECK_END) deal_en = 1'b0;
    end

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            ptr              <= '0;
            shuffled         <= 1'b0;
            wait_cnt         <= '0;
            init_idx         <= '0;
            embaralhar_start <= 1'b0;
            card_valid       <= 1'b0;
            card_value       <= '0;
            card_dest        <= 1'b0;
            cnt_jogador      <= '0;
            cnt_banca        <= '0;
            pronto           <= 1'b0;
            deck_empty       <= 1'b0;
            erro_shuffle     <= 1'b0;
        end else begin
            embaralhar_start <= 1'b0;
            card_valid       <= 1'b0;
            pronto           <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start_round) begin
                        if (!shuffled) begin
                            embaralhar_start <= 1'b1;
                            state            <= SHUF_REQ;
                        end else begin
                            // Deck already shuffled: continue from the
                            // current pointer, no rewind.
                            cnt_jogador <= '0;
                            cnt_banca   <= '0;
                            init_idx    <= '0;
                            state       <= INIT_DEAL;
                        end
                    end
                end
                SHUF_REQ: begin
                    wait_cnt <= '0;
                    state    <= SHUF_WAIT;
                end
                SHUF_WAIT: begin
                    if (bus.embaralhar_ok) begin
                        shuffled    <= 1'b1;
                        cnt_jogador <= '0;
                        cnt_banca   <= '0;
                        init_idx    <= '0;
                        state       <= INIT_DEAL;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        erro_shuffle <= 1'b1;
                        state        <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                INIT_DEAL: begin
                    init_idx <= init_idx + 4'd1;
                    if (init_idx == INIT_LAST) begin
                        state  <= SERVE;
                        pronto <= 1'b1;
                    end
                end
                SERVE: begin
                    if (bus.start_round) begin
                        cnt_jogador <= '0;
                        cnt_banca   <= '0;
                        init_idx    <= '0;
                        state       <= INIT_DEAL;
                    end else begin
                        pronto <= 1'b1;
                    end
                end
                EMPTY, ERROR: ;
                default: state <= IDLE;
            endcase

            // Card capture overrides the state case: exhaustion must win over
            // the INIT_DEAL -> SERVE transition.
            if (deal_en) begin
                card_valid <= 1'b1;
                card_value <= bus.q;
                card_dest  <= deal_dest;
                ptr        <= ptr + 6'd1;
                if (deal_dest) cnt_banca   <= sat_inc(cnt_banca);
                else           cnt_jogador <= sat_inc(cnt_jogador);
                if (ptr == LAST_ADDR) begin
                    deck_empty <= 1'b1;
                    pronto     <= 1'b0;
                    state      <= EMPTY;
                end
            end
        end
    end

    assign bus.ler_endereco     = ptr;
    assign bus.embaralhar_start = embaralhar_start;
    assign bus.card_valid       = card_valid;
    assign bus.card_value       = card_value;
    assign bus.card_dest        = card_dest;
    assign bus.cnt_jogador      = cnt_jogador;
    assign bus.cnt_banca        = cnt_banca;
    assign bus.pronto           = pronto;
    assign bus.deck_empty       = deck_empty;
    assign bus.erro_shuffle     = erro_shuffle;

endmodule

// File: tb/tb_distribuidor_cartas.sv
// -----------------------------------------------------------------------------
// tb_distribuidor_cartas
// Bench for distribuidor_cartas. The deck memory is an array of random card
// values; the reference model tracks the next deck index and per-hand counts
// and predicts each dealt card from the dealing rules.
// -----------------------------------------------------------------------------
module tb_distribuidor_cartas;

    localparam int DECK = 52;

    logic clock;
    logic reset;

    distribuidor_cartas_if bus ();

    distribuidor_cartas #(
        .DECK_SIZE       (DECK),
        .INIT_CARDS      (4),
        .SHUFFLE_TIMEOUT (1023)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [3:0] deck [64];

    assign bus.q = (bus.ler_endereco < 6'(DECK)) ? deck[bus.ler_endereco] : 4'd0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: next deck index and cards per hand this round.
    int m_ptr = 0;
    int m_cj  = 0;
    int m_cb  = 0;

    typedef struct {
        logic  req_j;
        logic  req_b;
        logic  exp_valid;
        logic  exp_dest;
        string name;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start_round   = 1'b0;
        bus.req_jogador   = 1'b0;
        bus.req_banca     = 1'b0;
        bus.embaralhar_ok = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},    32'(bus.ler_endereco),     0);
        check({tag, "_valid"},   32'(bus.card_valid),       0);
        check({tag, "_value"},   32'(bus.card_value),       0);
        check({tag, "_dest"},    32'(bus.card_dest),        0);
        check({tag, "_cj"},      32'(bus.cnt_jogador),      0);
        check({tag, "_cb"},      32'(bus.cnt_banca),        0);
        check({tag, "_pronto"},  32'(bus.pronto),           0);
        check({tag, "_empty"},   32'(bus.deck_empty),       0);
        check({tag, "_erro"},    32'(bus.erro_shuffle),     0);
        check({tag, "_shuf"},    32'(bus.embaralhar_start), 0);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_ptr = 0;
        m_cj  = 0;
        m_cb  = 0;
        check_all_zero("reset");
    endtask

    // A card dealt last cycle must appear now, with the value at the model's
    // next deck index.
    task automatic expect_card(input string name, input logic dest);
        logic [3:0] exp_val;
        exp_val = deck[m_ptr];
        m_ptr++;
        if (dest) begin
            if (m_cb < 15) m_cb++;
        end else begin
            if (m_cj < 15) m_cj++;
        end
        check({name, "_valid"}, 32'(bus.card_valid),   1);
        check({name, "_dest"},  32'(bus.card_dest),    32'(dest));
        check({name, "_value"}, 32'(bus.card_value),   32'(exp_val));
        check({name, "_addr"},  32'(bus.ler_endereco), m_ptr);
        check({name, "_cj"},    32'(bus.cnt_jogador),  m_cj);
        check({name, "_cb"},    32'(bus.cnt_banca),    m_cb);
        check({name, "_empty"}, 32'(bus.deck_empty),   (m_ptr == DECK) ? 1 : 0);
    endtask

    task automatic expect_none(input string name);
        check({name, "_valid"}, 32'(bus.card_valid),   0);
        check({name, "_addr"},  32'(bus.ler_endereco), m_ptr);
        check({name, "_cj"},    32'(bus.cnt_jogador),  m_cj);
        check({name, "_cb"},    32'(bus.cnt_banca),    m_cb);
    endtask

    // Opening hand: four cards P,D,P,D on consecutive cycles. req_banca is
    // held high throughout to show requests do not disturb the sequence.
    task automatic deal_opening(input string tag);
        bus.req_banca = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_card($sformatf("%s_card%0d", tag, i), 1'(i % 2));
            if (i == 2) check({tag, "_pronto_early"}, 32'(bus.pronto), 0);
        end
        bus.req_banca = 1'b0;
        check({tag, "_pronto"}, 32'(bus.pronto), 1);
    endtask

    task automatic start_and_shuffle(input string tag);
        bus.start_round = 1'b1;
        tick();
        bus.start_round = 1'b0;
        check({tag, "_shuf_req"}, 32'(bus.embaralhar_start), 1);
        tick();
        check({tag, "_shuf_len"}, 32'(bus.embaralhar_start), 0);
        tick();
        check({tag, "_wait_novalid"}, 32'(bus.card_valid), 0);
        bus.embaralhar_ok = 1'b1;
        tick();
        check({tag, "_init_novalid"}, 32'(bus.card_valid), 0);
        check({tag, "_init_cj"}, 32'(bus.cnt_jogador), 0);
    endtask

    initial begin
        int budget;
        logic rj;
        logic rb;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, "tbl_idle"};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, "tbl_player"};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, "tbl_dealer"};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, "tbl_both"};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, "tbl_idle2"};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, "tbl_dealer2"};

        for (int i = 0; i < 64; i++)
            deck[i] = (i < DECK) ? 4'($urandom_range(1, 11)) : 4'd0;

        reset = 1'b1;
        clear_inputs();

        // First round: shuffle then opening hand from addresses 0..3.
        do_reset();
        start_and_shuffle("r1");
        deal_opening("r1");
        check("r1_cj2", 32'(bus.cnt_jogador), 2);
        check("r1_cb2", 32'(bus.cnt_banca), 2);

        // Simultaneous requests: player wins, dealer request dropped.
        bus.req_jogador = 1'b1;
        bus.req_banca   = 1'b1;
        tick();
        bus.req_jogador = 1'b0;
        bus.req_banca   = 1'b0;
        expect_card("both_req", 1'b0);
        tick();
        expect_none("both_dropped");
        bus.req_banca = 1'b1;
        tick();
        bus.req_banca = 1'b0;
        expect_card("banca_alone", 1'b1);
        check("banca_cnt3", 32'(bus.cnt_banca), 3);

        // Second round after 6 cards: no reshuffle, no rewind. A request in
        // the start_round cycle is dropped.
        bus.start_round = 1'b1;
        bus.req_jogador = 1'b1;
        tick();
        bus.start_round = 1'b0;
        bus.req_jogador = 1'b0;
        m_cj = 0;
        m_cb = 0;
        check("r2_no_shuf", 32'(bus.embaralhar_start), 0);
        check("r2_pronto_low", 32'(bus.pronto), 0);
        expect_none("r2_start");
        deal_opening("r2");

        // Arbitration table in SERVE.
        foreach (vecs[i]) begin
            bus.req_jogador = vecs[i].req_j;
            bus.req_banca   = vecs[i].req_b;
            tick();
            bus.req_jogador = 1'b0;
            bus.req_banca   = 1'b0;
            if (vecs[i].exp_valid) expect_card(vecs[i].name, vecs[i].exp_dest);
            else                   expect_none(vecs[i].name);
        end

        // Random requests against the model.
        for (int i = 0; i < 30; i++) begin
            if (m_ptr >= DECK - 2) break;
            rj = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            bus.req_jogador = rj;
            bus.req_banca   = rb;
            tick();
            bus.req_jogador = 1'b0;
            bus.req_banca   = 1'b0;
            if (rj || rb) expect_card($sformatf("rnd%0d", i), rj ? 1'b0 : 1'b1);
            else          expect_none($sformatf("rnd%0d", i));
        end

        // Drain the deck with a held player request (count saturates at 15).
        budget = 64;
        bus.req_jogador = 1'b1;
        while (m_ptr < DECK && budget > 0) begin
            tick();
            expect_card($sformatf("drain%0d", m_ptr), 1'b0);
            budget--;
        end
        check("drain_budget", 32'(m_ptr), DECK);
        check("empty_flag", 32'(bus.deck_empty), 1);
        check("empty_pronto", 32'(bus.pronto), 0);
        for (int i = 0; i < 4; i++) begin
            bus.start_round = 1'(i % 2);
            tick();
            expect_none($sformatf("empty_hold%0d", i));
            check($sformatf("empty_addr%0d", i), 32'(bus.ler_endereco), DECK);
        end
        clear_inputs();

        // Reset in the middle of the opening hand.
        do_reset();
        start_and_shuffle("r3");
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_card($sformatf("r3_card%0d", i), 1'(i % 2));
        end
        reset = 1'b1;
        bus.embaralhar_ok = 1'b0;
        tick();
        check_all_zero("midreset");
        reset = 1'b0;
        m_ptr = 0;
        m_cj  = 0;
        m_cb  = 0;

        // Shuffle is requested again; then embaralhar_ok never rises.
        bus.start_round = 1'b1;
        tick();
        bus.start_round = 1'b0;
        check("r4_shuf_again", 32'(bus.embaralhar_start), 1);
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bus.card_valid !== 1'b0 || bus.erro_shuffle !== 1'b0) break;
        end
        check("timeout_early_erro", 32'(bus.erro_shuffle), 0);
        check("timeout_early_valid", 32'(bus.card_valid), 0);
        for (int i = 0; i < 100; i++) tick();
        check("timeout_erro", 32'(bus.erro_shuffle), 1);
        expect_none("timeout_novalid");

        // ERROR is terminal: start_round and requests are ignored.
        bus.start_round = 1'b1;
        bus.req_jogador = 1'b1;
        tick();
        bus.start_round = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("err_shuf%0d", i), 32'(bus.embaralhar_start), 0);
            expect_none($sformatf("err_hold%0d", i));
            check($sformatf("err_sticky%0d", i), 32'(bus.erro_shuffle), 1);
        end
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
